// File: rtl/sl_preceptron_mac.sv
// ---------------------------------------------------------------------------
// sl_preceptron_mac
//
// Perceptron compute stage that sits behind the 4:1 gear FIFO. Each feature
// of a vector is multiplied by its stored signed weight. The products are
// summed in a saturating accumulator, and a bias is added at the end. The
// block produces one signed dot-product sum and a binary class decision per
// vector.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   weight_wr_en/addr/data   weight memory write (honoured only in IDLE)
//   bias_wr_en/data          bias register write (honoured only in IDLE)
//   start_vector_processing  one-cycle pulse that opens a vector
//   data_in_valid / data_in  unsigned feature stream
//   done_vector_processing   one-cycle pulse that closes a vector
//   busy                     high in every state except IDLE
//   result_valid             one-cycle strobe when result_sum is updated
//   result_sum               saturated signed sum of products plus bias
//   result_class             1 when result_sum >= 0
//   count_error              feature count differed from NUM_FEATURES
// ---------------------------------------------------------------------------
module sl_preceptron_mac #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int NUM_FEATURES = 52,
    parameter int ADDR_WIDTH   = 6,
    parameter int ACC_WIDTH    = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           weight_wr_en,
    input  logic        [ADDR_WIDTH-1:0]   weight_wr_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_wr_data,
    input  logic                           bias_wr_en,
    input  logic signed [ACC_WIDTH-1:0]    bias_wr_data,
    input  logic                           start_vector_processing,
    input  logic                           data_in_valid,
    input  logic        [DATA_WIDTH-1:0]   data_in,
    input  logic                           done_vector_processing,
    output logic                           busy,
    output logic                           result_valid,
    output logic signed [ACC_WIDTH-1:0]    result_sum,
    output logic                           result_class,
    output logic                           count_error
);

    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH + 1;
    // One extra bit so the counter can hold NUM_FEATURES itself even when
    // NUM_FEATURES == 2**ADDR_WIDTH.
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LP_NF = CNT_W'(NUM_FEATURES);
    localparam logic signed [ACC_WIDTH-1:0] LP_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] LP_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DRAIN  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    // Saturating signed add: an overflow shows up as disagreement between
    // the two top bits of the one-bit-wider sum.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? LP_ACC_MIN : LP_ACC_MAX;
        return s[ACC_WIDTH-1:0];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
        input logic signed [PROD_W-1:0] p
    );
        return {{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    state_t                         r_state;
    state_t                         w_next_state;
    logic                           r_drain_cnt;

    logic signed [WEIGHT_WIDTH-1:0] r_weight_mem [NUM_FEATURES];
    logic signed [ACC_WIDTH-1:0]    r_bias;

    logic signed [PROD_W-1:0]       r_prod_p1;
    logic                           r_vld_p1;
    logic signed [ACC_WIDTH-1:0]    r_acc_p2;
    logic        [CNT_W-1:0]        r_idx;
    logic                           r_cerr;
    logic signed [ACC_WIDTH-1:0]    r_sum;
    logic                           r_class;
    logic                           r_rvld;

    logic                           w_in_accum;
    logic                           w_start_acpt;
    logic                           w_done_acpt;
    logic                           w_beat;
    logic                           w_take;
    logic                           w_drop;
    logic        [CNT_W-1:0]        w_rd_idx;
    logic        [CNT_W-1:0]        w_idx_next;
    logic                           w_in_range;
    logic signed [WEIGHT_WIDTH-1:0] w_weight;
    logic signed [PROD_W-1:0]       w_feat_ext;
    logic signed [PROD_W-1:0]       w_wt_ext;
    logic signed [PROD_W-1:0]       w_prod;
    logic signed [ACC_WIDTH-1:0]    w_final;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_in_accum   = (r_state == S_ACCUM);
    // A start in ACCUM aborts and restarts; in DRAIN/RESULT it is ignored.
    assign w_start_acpt = start_vector_processing &&
                          ((r_state == S_IDLE) || w_in_accum);
    // Start has priority over a coincident done.
    assign w_done_acpt  = done_vector_processing && w_in_accum &&
                          !start_vector_processing;

    // The beat that arrives with start is feature 0, so the read index is
    // forced to zero in that cycle regardless of the stale counter.
    assign w_rd_idx   = w_start_acpt ? '0 : r_idx;
    assign w_in_range = (w_rd_idx < LP_NF);
    assign w_beat     = data_in_valid && (w_in_accum || w_start_acpt);
    assign w_take     = w_beat && w_in_range;
    assign w_drop     = w_beat && !w_in_range;
    assign w_idx_next = w_rd_idx + {{(CNT_W-1){1'b0}}, w_take};

    assign w_weight   = w_in_range ? r_weight_mem[w_rd_idx[ADDR_WIDTH-1:0]] : '0;
    assign w_feat_ext = {{(PROD_W-DATA_WIDTH){1'b0}}, data_in};
    assign w_wt_ext   = {{(PROD_W-WEIGHT_WIDTH){w_weight[WEIGHT_WIDTH-1]}}, w_weight};
    assign w_prod     = w_feat_ext * w_wt_ext;

    assign w_final    = sat_add(r_acc_p2, r_bias);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_vector_processing)
                    w_next_state = S_ACCUM;
            end
            S_ACCUM: begin
                if (start_vector_processing)
                    w_next_state = S_ACCUM;
                else if (done_vector_processing)
                    w_next_state = S_DRAIN;
            end
            // Two cycles: one for the last product to land in the
            // accumulator and one of slack before the bias add.
            S_DRAIN: begin
                if (r_drain_cnt)
                    w_next_state = S_RESULT;
            end
            S_RESULT: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Configuration storage (not cleared by reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            if (weight_wr_en && ({1'b0, weight_wr_addr} < LP_NF))
                r_weight_mem[weight_wr_addr] <= weight_wr_data;
            if (bias_wr_en)
                r_bias <= bias_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: registered product
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            if (w_take)
                r_prod_p1 <= w_prod;
            r_vld_p1 <= w_take;
        end
    end

    // ------------------------------------------------------------------
    // Stage p2: saturating accumulate, feature count and count error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_p2 <= '0;
            r_idx    <= '0;
            r_cerr   <= 1'b0;
        end else begin
            // Clearing on start also discards any product still in p1
            // from an aborted vector.
            if (w_start_acpt)
                r_acc_p2 <= '0;
            else if (r_vld_p1)
                r_acc_p2 <= sat_add(r_acc_p2, sext_prod(r_prod_p1));

            if (w_start_acpt || w_take)
                r_idx <= w_idx_next;

            if (w_start_acpt)
                r_cerr <= w_drop;
            else if (w_drop || (w_done_acpt && (w_idx_next != LP_NF)))
                r_cerr <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_class <= 1'b0;
            r_rvld  <= 1'b0;
        end else begin
            r_rvld <= (r_state == S_RESULT);
            if (r_state == S_RESULT) begin
                r_sum   <= w_final;
                r_class <= ~w_final[ACC_WIDTH-1];
            end else if (w_start_acpt) begin
                r_sum   <= '0;
                r_class <= 1'b0;
            end
        end
    end

    assign result_valid = r_rvld;
    assign result_sum   = r_sum;
    assign result_class = r_class;
    assign count_error  = r_cerr;

endmodule

// File: tb/tb_sl_preceptron_mac.sv
module tb_sl_preceptron_mac;

    localparam int     NF   = 52;
    localparam longint MAXV = 64'sd8388607;
    localparam longint MINV = -64'sd8388608;
    localparam longint NEVER = 64'sh3fff_ffff_ffff_ffff;

    logic               clk = 1'b0;
    logic               rst;
    logic               weight_wr_en;
    logic        [5:0]  weight_wr_addr;
    logic signed [7:0]  weight_wr_data;
    logic               bias_wr_en;
    logic signed [23:0] bias_wr_data;
    logic               start_vector_processing;
    logic               data_in_valid;
    logic        [7:0]  data_in;
    logic               done_vector_processing;
    logic               busy;
    logic               result_valid;
    logic signed [23:0] result_sum;
    logic               result_class;
    logic               count_error;

    always #5 clk = ~clk;

    sl_preceptron_mac dut (
        .clk                     (clk),
        .rst                     (rst),
        .weight_wr_en            (weight_wr_en),
        .weight_wr_addr          (weight_wr_addr),
        .weight_wr_data          (weight_wr_data),
        .bias_wr_en              (bias_wr_en),
        .bias_wr_data            (bias_wr_data),
        .start_vector_processing (start_vector_processing),
        .data_in_valid           (data_in_valid),
        .data_in                 (data_in),
        .done_vector_processing  (done_vector_processing),
        .busy                    (busy),
        .result_valid            (result_valid),
        .result_sum              (result_sum),
        .result_class            (result_class),
        .count_error             (count_error)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc   = 0;
    bit     chk_en = 0;

    // Behavioural model state
    int     m_w [NF];
    longint m_bias = 0;
    bit     m_active = 0;
    int     m_data [$];
    bit     m_drop = 0;
    longint busy_start = NEVER;
    longint busy_end   = 0;

    typedef struct {
        longint due;
        longint sum;
        bit     cls;
        bit     cerr;
    } exp_t;
    exp_t   q [$];

    longint last_sum  = 0;
    bit     last_cerr = 0;
    bit     last_cls  = 0;
    int     n_results = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint clamp(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic bit model_idle();
        return !(cyc >= busy_start && cyc < busy_end);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // One clock of stimulus; the model is updated from the same values.
    task automatic drive(input bit st, input bit v, input int d, input bit dn,
                         input bit we = 0, input int wa = 0, input int wd = 0,
                         input bit be = 0, input longint bd = 0);
        bit     idle;
        longint acc;
        exp_t   e;
        idle = model_idle();
        start_vector_processing = st;
        data_in_valid           = v;
        data_in                 = d[7:0];
        done_vector_processing  = dn;
        weight_wr_en            = we;
        weight_wr_addr          = wa[5:0];
        weight_wr_data          = wd[7:0];
        bias_wr_en              = be;
        bias_wr_data            = bd[23:0];
        if (idle) begin
            if (we && wa < NF) m_w[wa] = wd;
            if (be) m_bias = bd;
        end
        if (st && (idle || m_active)) begin
            if (!m_active) busy_start = cyc + 1;
            busy_end = NEVER;
            m_active = 1;
            m_data.delete();
            m_drop = 0;
            if (v) m_data.push_back(d);
        end else if (m_active) begin
            if (v) begin
                if (m_data.size() < NF) m_data.push_back(d);
                else m_drop = 1;
            end
            if (dn) begin
                acc = 0;
                foreach (m_data[k]) acc = clamp(acc + longint'(m_data[k]) * m_w[k]);
                e.sum  = clamp(acc + m_bias);
                e.cls  = (e.sum >= 0);
                e.cerr = m_drop || (m_data.size() != NF);
                e.due  = cyc + 4;
                q.push_back(e);
                m_active = 0;
                busy_end = cyc + 4;
            end
        end
        @(posedge clk);
        #1;
        start_vector_processing = 0;
        data_in_valid           = 0;
        data_in                 = 0;
        done_vector_processing  = 0;
        weight_wr_en            = 0;
        bias_wr_en              = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        m_active = 0;
        q.delete();
        busy_end = cyc + 1;
        @(posedge clk);
        #1;
        rst = 0;
        check("rst_busy",         busy,         0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_sum",   result_sum,   0);
        check("rst_result_class", result_class, 0);
        check("rst_count_error",  count_error,  0);
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        while (q.size() > 0 && t < 30) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("result_timeout_pending", q.size(), 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic set_all_weights(input int w);
        for (int k = 0; k < NF; k++) drive(0, 0, 0, 0, 1, k, w);
    endtask

    task automatic set_bias(input longint b);
        drive(0, 0, 0, 0, 0, 0, 0, 1, b);
    endtask

    // Start carries feature 0; optional random idle gaps between beats.
    task automatic send_vec(input int dq[$], input bit done_on_last, input int gap_pct);
        drive(1, 1, dq[0], 0);
        for (int k = 1; k < dq.size(); k++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) drive(0, 0, 0, 0);
            drive(0, 1, dq[k], (done_on_last && k == dq.size() - 1));
        end
        if (!done_on_last) drive(0, 0, 0, 1);
        wait_result();
    endtask

    task automatic pin(input string name, input longint s, input bit cls, input bit cerr);
        check({name, "_sum"},   last_sum,  s);
        check({name, "_class"}, last_cls,  cls);
        check({name, "_cerr"},  last_cerr, cerr);
    endtask

    // Per-cycle comparison against the model
    initial forever begin
        bit exp_rv;
        @(negedge clk);
        if (chk_en) begin
            exp_rv = (q.size() > 0) && (q[0].due == cyc);
            check("result_valid", result_valid, exp_rv);
            check("busy", busy, !model_idle());
            if (exp_rv) begin
                check("result_sum",   result_sum,   q[0].sum);
                check("result_class", result_class, q[0].cls);
                check("count_error",  count_error,  q[0].cerr);
                last_sum  = result_sum;
                last_cls  = result_class;
                last_cerr = count_error;
                n_results++;
                void'(q.pop_front());
            end else if (q.size() > 0 && q[0].due < cyc) begin
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dq [$];
        int r0;
        int len;
        rst = 1;
        start_vector_processing = 0;
        data_in_valid = 0;
        data_in = 0;
        done_vector_processing = 0;
        weight_wr_en = 0;
        weight_wr_addr = 0;
        weight_wr_data = 0;
        bias_wr_en = 0;
        bias_wr_data = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        chk_en = 1;

        // Nominal
        set_all_weights(1);
        set_bias(0);
        dq.delete(); repeat (NF) dq.push_back(2);
        send_vec(dq, 0, 0);
        pin("nominal", 104, 1, 0);

        // Negative bias
        set_bias(-200);
        send_vec(dq, 0, 0);
        pin("neg_bias", -96, 0, 0);

        // Signed weights
        for (int k = 0; k < NF; k++) drive(0, 0, 0, 0, 1, k, (k % 2 == 0) ? -1 : 1);
        set_bias(0);
        dq.delete(); for (int k = 0; k < NF; k++) dq.push_back(k);
        send_vec(dq, 1, 0);
        pin("signed_w", 26, 1, 0);

        // Positive saturation
        set_all_weights(127);
        set_bias(MAXV);
        dq.delete(); repeat (NF) dq.push_back(255);
        send_vec(dq, 0, 0);
        pin("sat_pos", MAXV, 1, 0);

        // Negative saturation
        set_all_weights(-128);
        set_bias(-8388000);
        send_vec(dq, 0, 0);
        pin("sat_neg", MINV, 0, 0);

        // Count errors
        set_all_weights(1);
        set_bias(0);
        dq.delete(); repeat (40) dq.push_back(1);
        send_vec(dq, 0, 0);
        pin("short", 40, 1, 1);
        dq.delete(); repeat (60) dq.push_back(1);
        send_vec(dq, 0, 0);
        pin("long", 52, 1, 1);
        repeat (3) drive(0, 0, 0, 0);
        check("cerr_hold", count_error, 1);
        check("sum_hold", result_sum, 52);

        // Abort by restart after 20 beats
        r0 = n_results;
        drive(1, 1, 5, 0);
        repeat (19) drive(0, 1, 5, 0);
        dq.delete(); repeat (NF) dq.push_back(3);
        send_vec(dq, 0, 0);
        pin("abort", 156, 1, 0);
        check("abort_result_count", n_results - r0, 1);

        // Weight and bias writes while busy are ignored
        drive(1, 1, 1, 0);
        drive(0, 1, 1, 0, 1, 0, 100, 1, 1000);
        repeat (NF - 2) drive(0, 1, 1, 0);
        drive(0, 0, 0, 1);
        wait_result();
        pin("busy_write_a", 52, 1, 0);
        dq.delete(); repeat (NF) dq.push_back(1);
        send_vec(dq, 0, 0);
        pin("busy_write_b", 52, 1, 0);

        // Reset mid-ACCUM
        r0 = n_results;
        drive(1, 1, 7, 0);
        repeat (10) drive(0, 1, 7, 0);
        do_reset();
        repeat (12) drive(0, 0, 0, 0);
        check("rst_no_result", n_results - r0, 0);

        // Randomized vectors
        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < NF; k++)
                drive(0, 0, 0, 0, 1, k, int'($urandom_range(255)) - 128);
            if (v % 4 == 3) set_bias((v % 8 == 3) ? MAXV - 100 : MINV + 100);
            else set_bias(longint'($urandom_range(24'hFFFFFF)) - 64'sd8388608);
            r0 = $urandom_range(9);
            if (r0 < 6)      len = NF;
            else if (r0 < 8) len = 40 + $urandom_range(11);
            else             len = 53 + $urandom_range(6);
            dq.delete();
            for (int k = 0; k < len; k++) dq.push_back($urandom_range(255));
            send_vec(dq, bit'($urandom_range(1)), 20);
        end

        repeat (4) drive(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
